// File: rtl/apb4_regfile_slave.sv
// apb4_regfile_slave
//
// APB4 completer that maps a bank of NUM_REGS registers onto the bus.
// Supports PSTRB byte-lane writes, PSLVERR error responses (misaligned,
// out-of-range and writes to read-only registers), a fixed number of wait
// states and per-register read-only mapping from the ro_in input.
//
// Ports:
//   pclk      - bus clock, all logic on the rising edge
//   preset    - synchronous active-high reset
//   paddr     - byte address
//   psel      - select
//   penable   - access phase
//   pwrite    - 1 = write, 0 = read
//   pwdata    - write data
//   pstrb     - write byte strobes
//   prdata    - read data, valid when pready = 1
//   pready    - transfer completion
//   pslverr   - error response, valid when pready = 1
//   reg_q     - flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ro_in     - read-only source values, same slicing as reg_q
//   wr_pulse  - one-cycle pulse after the committed write to register i

module apb4_regfile_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int AL = $clog2(NB);
    localparam int IW = ADDR_WIDTH - AL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]     wrPulse_q, wrPulse_d;

    logic [ADDR_WIDTH-1:0]   curAddr;
    logic                    curWrite;
    logic [IW-1:0]           idx;
    logic                    selRo;
    logic [DATA_WIDTH-1:0]   rdVal;
    logic                    misalign;
    logic                    errRange;
    logic                    err;

    // In IDLE the request is still on the bus (a zero-wait transfer decodes
    // it in the setup cycle); afterwards the sampled copy is authoritative.
    always_comb begin
        curAddr  = (state_q == IDLE) ? paddr  : addr_q;
        curWrite = (state_q == IDLE) ? pwrite : write_q;
        idx      = curAddr[ADDR_WIDTH-1:AL];
        errRange = (32'(idx) >= NUM_REGS);
    end

    if (AL > 0) begin : gAlign
        assign misalign = |curAddr[AL-1:0];
    end else begin : gNoAlign
        assign misalign = 1'b0;
    end

    // Register select: read value and read-only flag of the addressed slot.
    // An out-of-range index matches nothing and leaves the defaults.
    always_comb begin
        selRo = 1'b0;
        rdVal = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IW'(i)) begin
                selRo = RO_MASK[i];
                rdVal = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
        err = misalign | errRange | (curWrite & selRo);
    end

    // Next-state logic: transfer sequencing, write commit and the values the
    // registered bus outputs take on the next edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        regs_d    = regs_q;
        wrPulse_d = '0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                // A dropped psel here is an abort; nothing is committed.
                if (psel && write_q && !err) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (idx == IW'(i) && !RO_MASK[i]) begin
                            wrPulse_d[i] = 1'b1;
                            for (int b = 0; b < NB; b++) begin
                                if (strb_q[b]) begin
                                    regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pready_d  = (state_d == DONE);
        pslverr_d = (state_d == DONE) && err;
        prdata_d  = ((state_d == DONE) && !curWrite && !err) ? rdVal : '0;
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wrPulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wrPulse_q <= wrPulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Completion and error are qualified by psel so an aborted transfer never
    // shows a stale pready/pslverr.
    assign pready   = pready_q & psel;
    assign pslverr  = pslverr_q & psel;
    assign prdata   = prdata_q;
    assign wr_pulse = wrPulse_q;

    // Read-only slots present the ro_in value; the rest show the stored data.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gRegOut
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[gi] ? ro_in[gi*DATA_WIDTH +: DATA_WIDTH] : regs_q[gi];
    end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// tb_apb4_regfile_slave
//
// Self-checking bench for apb4_regfile_slave. Three instances share one APB
// bus (separate psel lines) with different wait-state and read-only setups:
//   u0: WAIT_STATES=0, RO_MASK=16'h0001
//   u1: WAIT_STATES=3, RO_MASK=16'h0081
//   u2: WAIT_STATES=2, RO_MASK=16'h0001
// A behavioural register-array model supplies expectations for random
// traffic; directed vectors carry their own constant expectations.

module tb_apb4_regfile_slave;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int ND = 3;

    logic            pclk = 1'b0;
    logic            preset;
    logic [AW-1:0]   paddr;
    logic [ND-1:0]   psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [3:0]      pstrb;
    logic [NR*DW-1:0] roIn;

    logic [DW-1:0]    prdata  [ND];
    logic             pready  [ND];
    logic             pslverr [ND];
    logic [NR*DW-1:0] regQ    [ND];
    logic [NR-1:0]    wrPulse [ND];

    int          wsOf     [ND] = '{0, 3, 2};
    logic [15:0] roMaskOf [ND] = '{16'h0001, 16'h0081, 16'h0001};
    logic [31:0] model    [ND][NR];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          d;
        logic [11:0] a;
        bit          w;
        logic [31:0] wd;
        logic [3:0]  st;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    always #5 pclk = ~pclk;

    apb4_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                         .WAIT_STATES(0), .RO_MASK(16'h0001)) u0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[0]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
        .reg_q(regQ[0]), .ro_in(roIn), .wr_pulse(wrPulse[0]));

    apb4_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                         .WAIT_STATES(3), .RO_MASK(16'h0081)) u1 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[1]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
        .reg_q(regQ[1]), .ro_in(roIn), .wr_pulse(wrPulse[1]));

    apb4_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                         .WAIT_STATES(2), .RO_MASK(16'h0001)) u2 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel[2]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]),
        .reg_q(regQ[2]), .ro_in(roIn), .wr_pulse(wrPulse[2]));

    // Generic comparison with failure report.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All read-write slots of instance d must equal the model (one comparison).
    task automatic checkRegs(input string name, input int d);
        int bad;
        bad = -1;
        for (int i = 0; i < NR; i++) begin
            if (!roMaskOf[d][i] && regQ[d][i*DW +: DW] !== model[d][i] && bad < 0) begin
                bad = i;
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("[TB] FAIL %s: dut%0d reg%0d got %0h, expected %0h",
                     name, d, bad, regQ[d][bad*DW +: DW], model[d][bad]);
        end
    endtask

    function automatic bit modelErr(input int d, input logic [11:0] a, input bit w);
        int idx;
        idx = int'(a) / 4;
        if (int'(a) % 4 != 0) return 1'b1;
        if (idx >= NR) return 1'b1;
        if (w && roMaskOf[d][idx]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input int d, input logic [11:0] a);
        int idx;
        idx = int'(a) / 4;
        if (roMaskOf[d][idx]) return roIn[idx*DW +: DW];
        return model[d][idx];
    endfunction

    task automatic modelReset();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < NR; i++) begin
                model[d][i] = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        psel    = '0;
        penable = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    // One complete APB transfer, starting at a negedge and ending at the
    // negedge after completion with the bus released, so consecutive calls
    // are back-to-back with no idle cycle.
    task automatic applyStimulus(input int d, input logic [11:0] a, input bit w,
                                 input logic [31:0] wd, input logic [3:0] st,
                                 input bit expErr, input logic [31:0] expRd);
        int          waits;
        bit          done;
        int          idx;
        logic [15:0] expPulse;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = wd;
        pstrb   = st;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (pready[d]) begin
                done = 1'b1;
            end else begin
                checkOutput("pslverr-while-waiting", 64'(pslverr[d]), 64'd0);
                checkRegs("no-early-commit", d);
                waits++;
                @(negedge pclk);
            end
        end
        checkOutput("pready-seen", 64'(done), 64'd1);
        checkOutput("wait-cycles", 64'(waits), 64'(wsOf[d]));
        checkOutput("pslverr", 64'(pslverr[d]), 64'(expErr));
        checkOutput("prdata", 64'(prdata[d]), 64'(expRd));
        idx      = int'(a) / 4;
        expPulse = '0;
        if (w && !expErr) begin
            expPulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (st[b]) model[d][idx][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        @(negedge pclk);
        checkOutput("pready-one-cycle", 64'(pready[d]), 64'd0);
        checkOutput("wr_pulse", 64'(wrPulse[d]), 64'(expPulse));
        checkRegs("regs-after", d);
        psel    = '0;
        penable = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        bit          w;
        bit          e;
        int          d;
        int          sel;

        for (int i = 0; i < NR; i++) begin
            roIn[i*DW +: DW] = 32'h7777_0000 | 32'(i);
        end
        roIn[31:0] = 32'hCAFEF00D;

        vecs.push_back('{0, 12'h004, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{0, 12'h004, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{0, 12'h008, 1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{0, 12'h008, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0});
        vecs.push_back('{0, 12'h008, 1'b0, 32'h0,        4'h0, 1'b0, 32'h11BB33DD});
        vecs.push_back('{0, 12'h006, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0});
        vecs.push_back('{0, 12'h040, 1'b1, 32'h12345678, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{0, 12'h000, 1'b1, 32'h12345678, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{0, 12'h000, 1'b0, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D});
        vecs.push_back('{1, 12'h010, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1, 12'h010, 1'b0, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5});
        vecs.push_back('{1, 12'h01C, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1, 12'h01C, 1'b0, 32'h0,        4'h0, 1'b0, 32'h77770007});
        vecs.push_back('{1, 12'h3FC, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0});
        vecs.push_back('{1, 12'h00C, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0});
        vecs.push_back('{1, 12'h00C, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0});
        vecs.push_back('{1, 12'h011, 1'b1, 32'h0000FFFF, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{2, 12'h020, 1'b1, 32'h01020304, 4'h3, 1'b0, 32'h0});
        vecs.push_back('{2, 12'h020, 1'b0, 32'h0,        4'h0, 1'b0, 32'h00000304});

        // Reset state
        preset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        modelReset();
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        for (int i = 0; i < ND; i++) begin
            checkOutput("reset-prdata", 64'(prdata[i]), 64'd0);
            checkOutput("reset-pready", 64'(pready[i]), 64'd0);
            checkOutput("reset-pslverr", 64'(pslverr[i]), 64'd0);
            checkOutput("reset-wr_pulse", 64'(wrPulse[i]), 64'd0);
            checkRegs("reset-regs", i);
        end

        // Directed table, applied back-to-back
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].d, vecs[k].a, vecs[k].w, vecs[k].wd, vecs[k].st,
                          vecs[k].err, vecs[k].rd);
        end
        idle(1);

        // Back-to-back writes to 0x008 and 0x00C, then read both back
        applyStimulus(0, 12'h008, 1'b1, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
        applyStimulus(0, 12'h00C, 1'b1, 32'h600DCAFE, 4'hF, 1'b0, 32'h0);
        applyStimulus(0, 12'h008, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);
        applyStimulus(0, 12'h00C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h600DCAFE);
        idle(1);

        // Master abort: psel dropped in the 2nd access cycle of a 2-wait write
        psel    = 3'b100;
        penable = 1'b0;
        paddr   = 12'h014;
        pwrite  = 1'b1;
        pwdata  = 32'h55AA55AA;
        pstrb   = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        checkOutput("abort-access1-pready", 64'(pready[2]), 64'd0);
        @(negedge pclk);
        psel    = '0;
        penable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            checkOutput("abort-pready", 64'(pready[2]), 64'd0);
            checkOutput("abort-pslverr", 64'(pslverr[2]), 64'd0);
            checkOutput("abort-wr_pulse", 64'(wrPulse[2]), 64'd0);
        end
        checkRegs("abort-regs", 2);
        applyStimulus(2, 12'h014, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(1);

        // Randomised traffic against the model
        for (int n = 0; n < 90; n++) begin
            d   = int'($urandom_range(0, ND - 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 7) begin
                a = 12'($urandom_range(0, NR - 1) * 4);
            end else if (sel == 7) begin
                a = 12'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
            end else begin
                a = 12'($urandom_range(NR, 1023) * 4);
            end
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            e  = modelErr(d, a, w);
            if ($urandom_range(0, 3) == 0) idle(1);
            applyStimulus(d, a, w, wd, st, e, (w || e) ? 32'h0 : modelRead(d, a));
        end
        idle(1);

        // Reset during the completion cycle of a zero-wait write
        psel    = 3'b001;
        penable = 1'b0;
        paddr   = 12'h01C;
        pwrite  = 1'b1;
        pwdata  = 32'h12345678;
        pstrb   = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        checkOutput("rst-mid-pready-before", 64'(pready[0]), 64'd1);
        preset = 1'b1;
        modelReset();
        @(negedge pclk);
        checkOutput("rst-mid-pready-after", 64'(pready[0]), 64'd0);
        checkOutput("rst-mid-wr_pulse", 64'(wrPulse[0]), 64'd0);
        for (int i = 0; i < ND; i++) begin
            checkRegs("rst-mid-regs", i);
        end
        preset  = 1'b0;
        psel    = '0;
        penable = 1'b0;
        @(negedge pclk);
        checkOutput("rst-after-wr_pulse", 64'(wrPulse[0]), 64'd0);
        checkRegs("rst-after-regs", 0);
        applyStimulus(0, 12'h01C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(0, 12'h004, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1, 12'h010, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb4_regfile_slave.md
Name: apb4_regfile_slave

Overview:
Parametrised APB4 completer that terminates the team's APB bus in a bank of memory-mapped registers. It adds PSTRB byte-lane writes, PSLVERR error responses, a configurable number of wait states and per-register read-only mapping. It sits behind the APB interconnect as the generic peripheral register block; the hardware side sees the register contents and per-register write strobes.

Parameters:
ADDR_WIDTH, 12, width of paddr
DATA_WIDTH, 32, APB data width; must be 8, 16 or 32
NUM_REGS, 16, number of registers; must be 1..2^(ADDR_WIDTH-AL), where AL = log2(DATA_WIDTH/8)
WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15)
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from ro_in

Ports:
pclk  input  1  bus clock; all logic is on the rising edge
preset  input  1  synchronous, active-high reset
paddr  input  ADDR_WIDTH  byte address
psel  input  1  select
penable  input  1  access phase
pwrite  input  1  1=write, 0=read
pwdata  input  DATA_WIDTH  write data
pstrb  input  DATA_WIDTH/8  write byte strobes
prdata  output  DATA_WIDTH  read data, valid when pready=1
pready  output  1  transfer completion
pslverr  output  1  error response, valid when pready=1
reg_q  output  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
ro_in  input  NUM_REGS*DATA_WIDTH  read-only source values (same slicing); only used where RO_MASK=1
wr_pulse  output  NUM_REGS  one-cycle pulse on the committed write to register i

Behaviour:
- Reset (preset=1 at a pclk edge) forces state to IDLE and clears all of the following: prdata, pready, pslverr, wr_pulse, every RW register and the wait counter. Reset in the middle of an access aborts the transfer and commits nothing.
- Decode:
  - idx = paddr[ADDR_WIDTH-1:AL].
  - err_align = (paddr[AL-1:0] != 0); not applicable when AL=0.
  - err_range = (idx >= NUM_REGS).
  - err_ro = pwrite && RO_MASK[idx].
  - err = err_align | err_range | err_ro.
  - paddr, pwrite, pwdata and pstrb are sampled in the setup cycle and held internally.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on psel=1 and penable=0, sample the request and load cnt=WAIT_STATES. Go to DONE if WAIT_STATES=0, otherwise go to WAIT.
  - WAIT: pready=0. cnt decrements each cycle; when cnt reaches 1, go to DONE.
  - DONE: pready=1 for exactly one cycle while psel=1 and penable=1. pslverr = err. prdata = selected value on a read with no error, otherwise 0. Then return to IDLE.
- Outputs are registered. With WAIT_STATES=N, the access phase lasts N+1 cycles.
- Write commit happens at the DONE edge, only when pwrite=1 and err=0:
  - for each byte lane b with pstrb[b]=1, reg[idx] byte b takes pwdata byte b;
  - lanes with pstrb[b]=0 keep their value;
  - wr_pulse[idx]=1 for the following cycle, even if pstrb=0.
- Read value: ro_in slice if RO_MASK[idx], otherwise reg[idx]. It is captured in the last cycle before DONE.
- Errored writes change no register and raise no wr_pulse. Reads of read-only registers are legal.
- Master abort: psel=0 in WAIT or DONE returns the FSM to IDLE with no commit, pready=0, and no pslverr.
- Back-to-back: a new setup phase in the cycle after DONE is accepted directly from IDLE with no bubble.
- pready and pslverr are 0 whenever psel=0. pslverr is never 1 while pready=0.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x004 with pstrb=4'hF, then read 0x004 → pready high in the first access cycle; prdata=0xDEADBEEF; wr_pulse[1] pulses once; pslverr=0.
- Partial write: reg2=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 → read returns 0x11BB33DD.
- WAIT_STATES=3: any transfer → pready low for 3 access cycles, high on the 4th; a write commits only on the completion edge.
- Errors:
  - read 0x006 (misaligned) → pslverr=1 and prdata=0;
  - write to 0x040 (idx 16, out of range) → pslverr=1 and no wr_pulse;
  - RO_MASK=16'h0001, write to 0x000 → pslverr=1 and reg unchanged; reading 0x000 returns ro_in[31:0]=0xCAFEF00D.
- Abort and reset: with WAIT_STATES=2, drop psel in the 2nd access cycle → no commit; preset mid-write → all regs=0 and pready=0 next cycle; back-to-back writes to 0x008 and 0x00C with no idle cycle → both committed.
